apb_requester: RTL and testbench



---
 rtl/apb_requester_if.sv | 61 ++++++
 rtl/apb_requester.sv | 141 ++++++++++++++
 tb/tb_apb_requester.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_requester_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_requester_if
// Purpose  : Bundles the client command/response channel and the APB4 bus
//            seen by apb_requester.
//   master : the requester's view. It receives client commands and
//            completer responses, and drives cmd_ready, rsp_* and the APB
//            request signals.
//   slave  : the environment's view (client plus completer).
// Signals  : cmd_valid/ready/write/addr/wdata/strb/prot,
//            rsp_valid/rdata/err/timeout,
//            PSEL PENABLE PWRITE PADDR PWDATA PSTRB PPROT,
//            PREADY PSLVERR PRDATA
// Revision : 1.0 - initial release
// ============================================================================
interface apb_requester_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) ();
  localparam int c_STRB_W = DATA_WIDTH / 8;

  // client command / response channel
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [c_STRB_W-1:0]   cmd_strb;
  logic [2:0]            cmd_prot;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  // APB4 bus
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [c_STRB_W-1:0]   PSTRB;
  logic [2:0]            PPROT;
  logic                  PREADY;
  logic                  PSLVERR;
  logic [DATA_WIDTH-1:0] PRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  PREADY, PSLVERR, PRDATA,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output PREADY, PSLVERR, PRDATA,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
  );
endinterface
`default_nettype wire

// File: rtl/apb_requester.sv
`default_nettype none
// ============================================================================
// Module   : apb_requester
// Purpose  : APB4 requester. Converts single-word client commands into
//            APB SETUP/ACCESS transfers and returns exactly one response per
//            command. Misaligned addresses are rejected locally, without a
//            bus cycle. ACCESS wait states are bounded by a timeout.
// Ports    : PCLK   - clock, rising edge
//            PRESET - synchronous active-high reset
//            bus    - apb_requester_if.master (command, response, APB)
// Revision : 1.0 - initial release
// ============================================================================
module apb_requester #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input wire              PCLK,
  input wire              PRESET,
  apb_requester_if.master bus
);
  localparam int c_STRB_W = DATA_WIDTH / 8;
  localparam int c_CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_TO_LIMIT = c_CNT_W'(TIMEOUT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam bit c_TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [c_STRB_W-1:0]   r_pstrb;
  logic [2:0]            r_pprot;
  logic [c_CNT_W-1:0]    r_wait;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  r_rsp_timeout;

  logic w_cmd_ready;
  logic w_aligned;
  logic w_timeout;

  assign w_cmd_ready = (r_state == S_IDLE);
  assign w_aligned   = (bus.cmd_addr[1:0] == 2'b00);
  // r_wait equals the number of PREADY-low ACCESS cycles already seen, so
  // the abort happens in the ACCESS cycle that would exceed the limit.
  assign w_timeout   = c_TO_EN && (r_wait == c_TO_LIMIT);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state       <= S_IDLE;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_pprot       <= '0;
      r_wait        <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      // response is a single-cycle pulse; the rsp_* payload holds
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            if (w_aligned) begin
              r_paddr  <= bus.cmd_addr;
              r_pwrite <= bus.cmd_write;
              r_pprot  <= bus.cmd_prot;
              // reads must drive zero strobes on APB4
              r_pwdata <= bus.cmd_write ? bus.cmd_wdata : '0;
              r_pstrb  <= bus.cmd_write ? bus.cmd_strb  : '0;
              r_psel   <= 1'b1;
              r_state  <= S_SETUP;
            end else begin
              r_rsp_valid   <= 1'b1;
              r_rsp_err     <= 1'b1;
              r_rsp_timeout <= 1'b0;
              r_rsp_rdata   <= '0;
            end
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_wait    <= '0;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          // PREADY wins over a coincident timeout
          if (bus.PREADY) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= S_IDLE;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= bus.PSLVERR;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= (!r_pwrite && !bus.PSLVERR) ? bus.PRDATA : '0;
          end else if (w_timeout) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= S_IDLE;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_rdata   <= '0;
          end else begin
            r_wait <= r_wait + c_CNT_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.PSEL        = r_psel;
  assign bus.PENABLE     = r_penable;
  assign bus.PWRITE      = r_pwrite;
  assign bus.PADDR       = r_paddr;
  assign bus.PWDATA      = r_pwdata;
  assign bus.PSTRB       = r_pstrb;
  assign bus.PPROT       = r_pprot;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;
endmodule
`default_nettype wire

// File: tb/tb_apb_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_requester
// Purpose  : Self-checking bench for apb_requester. A RAM-style completer
//            with programmable wait states and error injection drives the
//            APB side. A command-level reference model predicts latency,
//            error/timeout flags and read data for every command.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_requester;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // completer storage (written from what appears on the bus) and the
  // model's own copy (written from the commands issued)
  logic [31:0] bus_mem [0:255];
  logic [31:0] ref_mem [0:255];

  // observations from the last transaction
  logic        ob_ready, ob_err, ob_to, ob_psel_seen, ob_bus_ok, ob_phase_ok, ob_psel_at_rsp;
  logic [31:0] ob_rdata;
  int          ob_lat, ob_nacc, ob_acc_entry;

  // model predictions
  logic        ex_err, ex_to, ex_psel;
  logic [31:0] ex_rdata;
  int          ex_lat, ex_nacc;

  // Command-level model: misaligned -> local error after 1 cycle; more
  // wait states than the limit -> timeout; otherwise 3 + waits cycles.
  task automatic model_cmd(input logic w, input logic [15:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int waits, input logic slverr);
    int idx = int'(addr[9:2]);
    ex_rdata = '0;
    ex_to    = 1'b0;
    ex_psel  = 1'b1;
    if (addr[1:0] != 2'b00) begin
      ex_lat = 1; ex_err = 1'b1; ex_psel = 1'b0; ex_nacc = 0;
    end else if (TO != 0 && waits > TO) begin
      ex_lat = TO + 3; ex_err = 1'b1; ex_to = 1'b1; ex_nacc = TO + 1;
    end else begin
      ex_lat = 3 + waits; ex_err = slverr; ex_nacc = waits + 1;
      if (!slverr) begin
        if (w) begin
          for (int b = 0; b < 4; b++)
            if (strb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end else begin
          ex_rdata = ref_mem[idx];
        end
      end
    end
  endtask

  // Issue one command (caller is at a negedge) and act as the completer
  // until the response appears; returns at the negedge of the response.
  task automatic run_cmd(input logic w, input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [2:0] prot,
                         input int waits, input logic slverr);
    logic first;
    ob_ready      = bus.cmd_ready;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
    bus.cmd_prot  = prot;
    @(posedge clk);
    @(negedge clk);
    // scramble the command inputs: they must not matter after accept
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = 16'($urandom);
    bus.cmd_wdata = $urandom;
    bus.cmd_strb  = 4'($urandom);
    bus.cmd_prot  = 3'($urandom);
    ob_lat = -1; ob_psel_seen = 0; ob_nacc = 0; ob_bus_ok = 1; ob_phase_ok = 1;
    ob_psel_at_rsp = 1; ob_acc_entry = -1; ob_err = 0; ob_to = 0; ob_rdata = '0;
    first = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (bus.rsp_valid) begin
        ob_lat = cyc; ob_err = bus.rsp_err; ob_to = bus.rsp_timeout;
        ob_rdata = bus.rsp_rdata; ob_psel_at_rsp = bus.PSEL;
        break;
      end
      // noise: completer inputs are meaningless outside ACCESS & PREADY
      bus.PREADY  = 1'($urandom);
      bus.PSLVERR = 1'($urandom);
      bus.PRDATA  = $urandom;
      if (bus.PSEL) begin
        ob_psel_seen = 1;
        if (bus.PADDR !== addr || bus.PWRITE !== w || bus.PPROT !== prot ||
            bus.PWDATA !== (w ? wdata : 32'h0) || bus.PSTRB !== (w ? strb : 4'h0))
          ob_bus_ok = 0;
        if (bus.PENABLE !== !first) ob_phase_ok = 0;
        if (bus.PENABLE) begin
          if (ob_acc_entry < 0) ob_acc_entry = cyc;
          if (ob_nacc == waits) begin
            bus.PREADY  = 1'b1;
            bus.PSLVERR = slverr;
            bus.PRDATA  = slverr ? $urandom : bus_mem[bus.PADDR[9:2]];
            if (bus.PWRITE && !slverr)
              for (int b = 0; b < 4; b++)
                if (bus.PSTRB[b]) bus_mem[bus.PADDR[9:2]][8*b +: 8] = bus.PWDATA[8*b +: 8];
          end else begin
            bus.PREADY = 1'b0;
          end
          ob_nacc++;
        end
        first = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PPROT} !== '0) begin
      failures++;
      $display("FAIL reset_apb act=%b%b%b %h %h %h %h exp=all zero", bus.PSEL, bus.PENABLE,
               bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PPROT);
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== '0) begin
      failures++;
      $display("FAIL reset_rsp act=%b %h %b %b exp=all zero", bus.rsp_valid, bus.rsp_rdata,
               bus.rsp_err, bus.rsp_timeout);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready act=%b exp=1", bus.cmd_ready);
    end
  endtask

  task automatic test_write_read();
    model_cmd(1, 16'h00A4, 32'hDEADBEEF, 4'hF, 0, 0);
    run_cmd(1, 16'h00A4, 32'hDEADBEEF, 4'hF, 3'd2, 0, 0);
    checks++;
    if (ob_lat !== ex_lat || ob_err !== ex_err || ob_lat !== 3) begin
      failures++; $display("FAIL wr_rsp act=lat%0d err%b exp=lat%0d err%b", ob_lat, ob_err, ex_lat, ex_err);
    end
    checks++;
    if (ob_nacc !== 1 || !ob_phase_ok || !ob_bus_ok) begin
      failures++; $display("FAIL wr_bus act=nacc%0d phase%b bus%b exp=nacc1 phase1 bus1", ob_nacc, ob_phase_ok, ob_bus_ok);
    end
    model_cmd(0, 16'h00A4, 32'h0, 4'h0, 0, 0);
    run_cmd(0, 16'h00A4, 32'h5555_5555, 4'hF, 3'd0, 0, 0);
    checks++;
    if (ob_ready !== 1'b1 || ob_rdata !== ex_rdata || ob_rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL rd_a4 act=rdy%b %h exp=rdy1 %h", ob_ready, ob_rdata, ex_rdata);
    end
    checks++;
    if (!ob_bus_ok || ob_err !== 1'b0) begin
      failures++; $display("FAIL rd_a4_bus act=bus%b err%b exp=bus1 err0", ob_bus_ok, ob_err);
    end
  endtask

  task automatic test_strobe();
    model_cmd(1, 16'h00A8, 32'hAAAAAAAA, 4'b1001, 0, 0);
    run_cmd(1, 16'h00A8, 32'hAAAAAAAA, 4'b1001, 3'd1, 0, 0);
    model_cmd(0, 16'h00A8, 32'h0, 4'h0, 0, 0);
    run_cmd(0, 16'h00A8, 32'h0, 4'h0, 3'd1, 0, 0);
    checks++;
    if (ob_rdata !== ex_rdata || ob_rdata !== 32'hAA0000AA) begin
      failures++; $display("FAIL strobe_rd act=%h exp=%h", ob_rdata, ex_rdata);
    end
  endtask

  task automatic test_wait_states();
    bus_mem[8'h30] = 32'h12345678;
    ref_mem[8'h30] = 32'h12345678;
    model_cmd(0, 16'h00C0, 32'h0, 4'h0, 3, 0);
    run_cmd(0, 16'h00C0, 32'h0, 4'h0, 3'd3, 3, 0);
    checks++;
    if (ob_lat !== ex_lat || ob_lat !== 6 || ob_rdata !== 32'h12345678) begin
      failures++; $display("FAIL wait_rd act=lat%0d %h exp=lat%0d %h", ob_lat, ob_rdata, ex_lat, ex_rdata);
    end
    checks++;
    if (ob_nacc !== ex_nacc || !ob_bus_ok || !ob_phase_ok) begin
      failures++; $display("FAIL wait_stable act=nacc%0d bus%b phase%b exp=nacc%0d bus1 phase1", ob_nacc, ob_bus_ok, ob_phase_ok, ex_nacc);
    end
  endtask

  task automatic test_misaligned();
    model_cmd(1, 16'h0181, 32'h1111_2222, 4'hF, 0, 0);
    run_cmd(1, 16'h0181, 32'h1111_2222, 4'hF, 3'd0, 0, 0);
    checks++;
    if (ob_psel_seen !== 1'b0 || ob_lat !== 1 || ob_err !== 1'b1 || ob_to !== 1'b0 || ob_rdata !== 32'h0) begin
      failures++; $display("FAIL misalign act=psel%b lat%0d err%b to%b %h exp=psel0 lat1 err1 to0 0", ob_psel_seen, ob_lat, ob_err, ob_to, ob_rdata);
    end
    // accept again in the very cycle of the error response
    model_cmd(0, 16'h00A8, 32'h0, 4'h0, 0, 0);
    run_cmd(0, 16'h00A8, 32'h0, 4'h0, 3'd0, 0, 0);
    checks++;
    if (ob_ready !== 1'b1 || ob_lat !== ex_lat || ob_rdata !== ex_rdata || ob_err !== 1'b0) begin
      failures++; $display("FAIL misalign_next act=rdy%b lat%0d %h err%b exp=rdy1 lat%0d %h err0", ob_ready, ob_lat, ob_rdata, ob_err, ex_lat, ex_rdata);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== ex_rdata) begin
      failures++; $display("FAIL rsp_pulse act=v%b %h exp=v0 %h", bus.rsp_valid, bus.rsp_rdata, ex_rdata);
    end
  endtask

  task automatic test_slverr();
    model_cmd(0, 16'h00A4, 32'h0, 4'h0, 1, 1);
    run_cmd(0, 16'h00A4, 32'h0, 4'h0, 3'd0, 1, 1);
    checks++;
    if (ob_err !== 1'b1 || ob_to !== 1'b0 || ob_rdata !== 32'h0 || ob_lat !== ex_lat) begin
      failures++; $display("FAIL slverr act=err%b to%b %h lat%0d exp=err1 to0 0 lat%0d", ob_err, ob_to, ob_rdata, ob_lat, ex_lat);
    end
  endtask

  task automatic test_timeout();
    model_cmd(0, 16'h00A4, 32'h0, 4'h0, 1000, 0);
    run_cmd(0, 16'h00A4, 32'h0, 4'h0, 3'd0, 1000, 0);
    checks++;
    if (ob_err !== 1'b1 || ob_to !== 1'b1 || ob_rdata !== 32'h0 || ob_lat !== ex_lat) begin
      failures++; $display("FAIL timeout act=err%b to%b %h lat%0d exp=err1 to1 0 lat%0d", ob_err, ob_to, ob_rdata, ob_lat, ex_lat);
    end
    checks++;
    if (ob_lat - ob_acc_entry !== TO + 1 || ob_psel_at_rsp !== 1'b0 || ob_nacc !== ex_nacc) begin
      failures++; $display("FAIL timeout_timing act=dist%0d psel%b nacc%0d exp=dist%0d psel0 nacc%0d", ob_lat - ob_acc_entry, ob_psel_at_rsp, ob_nacc, TO + 1, ex_nacc);
    end
    // PREADY in the last allowed cycle is a normal completion
    model_cmd(0, 16'h00A4, 32'h0, 4'h0, TO, 0);
    run_cmd(0, 16'h00A4, 32'h0, 4'h0, 3'd0, TO, 0);
    checks++;
    if (ob_err !== 1'b0 || ob_to !== 1'b0 || ob_rdata !== ex_rdata || ob_lat !== ex_lat) begin
      failures++; $display("FAIL timeout_edge act=err%b to%b %h lat%0d exp=err0 to0 %h lat%0d", ob_err, ob_to, ob_rdata, ob_lat, ex_rdata, ex_lat);
    end
  endtask

  task automatic test_reset_mid();
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 16'h00A4;
    bus.cmd_wdata = '0; bus.cmd_strb = '0; bus.cmd_prot = '0;
    bus.PREADY = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1) begin
      failures++; $display("FAIL rstmid_access act=%b%b exp=11", bus.PSEL, bus.PENABLE);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_drop act=%b%b v%b exp=00 v0", bus.PSEL, bus.PENABLE, bus.rsp_valid);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.PSEL !== 1'b0) begin
        failures++; $display("FAIL rstmid_after act=rdy%b v%b psel%b exp=rdy1 v0 psel0", bus.cmd_ready, bus.rsp_valid, bus.PSEL);
      end
    end
  endtask

  task automatic test_random();
    logic w, se;
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0] s;
    int wt, sel;
    for (int n = 0; n < 40; n++) begin
      w  = 1'($urandom);
      a  = 16'(16'h0200 + 4 * $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a = a + 16'($urandom_range(1, 3));
      d  = $urandom;
      s  = 4'($urandom);
      se = ($urandom_range(0, 5) == 0);
      sel = $urandom_range(0, 9);
      wt = (sel < 6) ? sel % 4 : (sel == 6) ? TO : (sel == 7) ? TO + 1 : (sel == 8) ? 1000 : 0;
      model_cmd(w, a, d, s, wt, se);
      run_cmd(w, a, d, s, 3'($urandom), wt, se);
      checks++;
      if (ob_ready !== 1'b1 || ob_lat !== ex_lat || ob_err !== ex_err || ob_to !== ex_to || ob_rdata !== ex_rdata) begin
        failures++;
        $display("FAIL rand_rsp n=%0d act=rdy%b lat%0d err%b to%b %h exp=rdy1 lat%0d err%b to%b %h",
                 n, ob_ready, ob_lat, ob_err, ob_to, ob_rdata, ex_lat, ex_err, ex_to, ex_rdata);
      end
      checks++;
      if (ob_psel_seen !== ex_psel || ob_nacc !== ex_nacc || !ob_bus_ok || !ob_phase_ok) begin
        failures++;
        $display("FAIL rand_bus n=%0d act=psel%b nacc%0d bus%b phase%b exp=psel%b nacc%0d bus1 phase1",
                 n, ob_psel_seen, ob_nacc, ob_bus_ok, ob_phase_ok, ex_psel, ex_nacc);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog act=still running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      bus_mem[i] = '0;
      ref_mem[i] = '0;
    end
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0; bus.cmd_strb = '0; bus.cmd_prot = '0;
    bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_write_read();
    test_strobe();
    test_wait_states();
    test_misaligned();
    test_slverr();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
